// File: rtl/gray_ds_ctrl.sv
// Frame controller for a 2:1 horizontal downsampler. It gates the pixel
// valid, optionally drops odd lines, and marks the first and last
// downsampled pixel of each kept line.
module gray_ds_ctrl #(
    parameter int unsigned WIDTH_BITS  = 12,
    parameter int unsigned HEIGHT_BITS = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH_BITS-1:0]  cfg_width,
    input  logic [HEIGHT_BITS-1:0] cfg_height,
    input  logic                   cfg_vskip,
    input  logic                   pixel_in_valid,
    output logic                   ds_clear,
    output logic                   ds_valid,
    output logic                   out_sol,
    output logic                   out_eol,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   cfg_err,
    output logic                   stray_err
);

    typedef enum logic [1:0] {StIdle, StClear, StActive, StDone} state_e;

    state_e                 state_q;
    logic [WIDTH_BITS-1:0]  col_q;
    logic [HEIGHT_BITS-1:0] row_q;
    logic [WIDTH_BITS-1:0]  width_q;
    logic [HEIGHT_BITS-1:0] height_q;
    logic                   vskip_q;
    logic                   ds_clear_q;
    logic                   out_sol_q;
    logic                   out_eol_q;
    logic                   frame_done_q;
    logic                   busy_q;
    logic                   cfg_err_q;
    logic                   stray_err_q;

    logic cfg_legal;
    logic row_kept;
    logic col_last;
    logic row_last;

    // Config checks and end-of-line/frame compares against the shadow copies.
    always_comb begin
        cfg_legal = (cfg_width[0] == 1'b0) && (cfg_width != '0) && (cfg_height != '0);
        row_kept  = !vskip_q || !row_q[0];
        col_last  = (col_q == width_q - WIDTH_BITS'(1));
        row_last  = (row_q == height_q - HEIGHT_BITS'(1));
        ds_valid  = pixel_in_valid && (state_q == StActive) && row_kept;
    end

    // Frame sequencing, line/column counting and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            vskip_q      <= 1'b0;
            ds_clear_q   <= 1'b1;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            stray_err_q  <= 1'b0;
        end else begin
            ds_clear_q   <= 1'b0;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            if (pixel_in_valid && state_q != StActive) begin
                stray_err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_legal) begin
                            width_q     <= cfg_width;
                            height_q    <= cfg_height;
                            vskip_q     <= cfg_vskip;
                            col_q       <= '0;
                            row_q       <= '0;
                            // A pixel dropped in this same cycle still counts as stray.
                            stray_err_q <= pixel_in_valid;
                            ds_clear_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= StClear;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    col_q <= '0;
                    row_q <= '0;
                    if (abort) begin
                        ds_clear_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        state_q <= StActive;
                    end
                end
                StActive: begin
                    if (abort) begin
                        // Abort beats a coincident last pixel: no markers, no frame_done.
                        col_q      <= '0;
                        row_q      <= '0;
                        ds_clear_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else if (pixel_in_valid) begin
                        if (ds_valid) begin
                            out_sol_q <= (col_q == WIDTH_BITS'(1));
                            out_eol_q <= col_last;
                        end
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q        <= '0;
                                frame_done_q <= 1'b1;
                                state_q      <= StDone;
                            end else begin
                                row_q <= row_q + HEIGHT_BITS'(1);
                            end
                        end else begin
                            col_q <= col_q + WIDTH_BITS'(1);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ds_clear   = ds_clear_q;
    assign out_sol    = out_sol_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign cfg_err    = cfg_err_q;
    assign stray_err  = stray_err_q;

endmodule
